// File: rtl/mii_rx_pkg.sv
// Shared definitions for the MII/GMII receive framer: FSM states, preamble/SFD
// codes for both PHY widths, error-bit positions and CRC-32 constants.
package mii_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } rx_state_e;

    // Preamble and start-of-frame delimiter codes, nibble (MII) and byte (GMII)
    localparam logic [3:0] PRE_MII  = 4'h5;
    localparam logic [3:0] SFD_MII  = 4'hD;
    localparam logic [7:0] PRE_GMII = 8'h55;
    localparam logic [7:0] SFD_GMII = 8'hD5;

    // out_err bit positions
    localparam int ERR_W        = 4;
    localparam int ERR_RUNT     = 0;
    localparam int ERR_OVERSIZE = 1;
    localparam int ERR_ODD      = 2;
    localparam int ERR_FCS      = 3;

    // CRC-32 (IEEE 802.3); the residue is given in MSB-first bit order
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Polynomial in the LSB-first (reflected) register orientation
    localparam logic [31:0] CRC_POLY_REFL = bitrev32(CRC_POLY);

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide combinational next-CRC for the reflected CRC-32 used on Ethernet.
// Data bits are consumed LSB first, matching wire order.
module crc32_d8
    import mii_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Eight unrolled shift-right steps of the reflected LFSR
    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_rx_framer.sv
// Ethernet RX front end: registers the PHY stream, detects preamble and SFD,
// assembles payload bytes (MII nibbles low-first, or GMII bytes) and reports
// per-frame length and error status.
// Optional FCS check: define MII_RX_FCS_CHECK_EN to build the CRC-32 checker;
// otherwise out_err[3] is tied to 0.
module mii_rx_framer
    import mii_rx_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int MIN_PRE = 7,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 16
) (
    input  logic              rxc,
    input  logic              rst,
    input  logic [DATA_W-1:0] rxd,
    input  logic              rxdv,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_sof,
    output logic              out_done,
    output logic [LEN_W-1:0]  out_len,
    output logic [ERR_W-1:0]  out_err,
    output logic              out_drop
);

    localparam int PRE_CW = $clog2(MIN_PRE + 1) + 1;

    localparam logic [DATA_W-1:0] PRE_C = (DATA_W == 8) ? DATA_W'(PRE_GMII) : DATA_W'(PRE_MII);
    localparam logic [DATA_W-1:0] SFD_C = (DATA_W == 8) ? DATA_W'(SFD_GMII) : DATA_W'(SFD_MII);
    localparam logic [PRE_CW-1:0] MIN_PRE_C = PRE_CW'(MIN_PRE);
    localparam logic [LEN_W-1:0]  MIN_LEN_C = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0]  MAX_LEN_C = LEN_W'(MAX_LEN);

    // Registered PHY inputs; all decisions below use these
    logic [DATA_W-1:0] rxd_q;
    logic              rxdv_q;
    logic              sampled_q;
    logic              armed_q;

    rx_state_e         state_q, state_d;
    logic [PRE_CW-1:0] pre_cnt_q, pre_cnt_d;
    logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic              half_q, half_d;
    logic [3:0]        nib_lo_q, nib_lo_d;
    logic              over_q, over_d;

    logic [7:0]        data_d;
    logic              valid_d, sof_d, done_d, drop_d;
    logic [LEN_W-1:0]  len_d;
    logic [ERR_W-1:0]  err_d;

    logic [7:0]        asm_byte;
    logic              unit_completes;
    logic              sfd_hit;
    logic              data_byte;
    logic              fcs_err;

    generate
        if (DATA_W == 8) begin : g_gmii
            assign asm_byte       = rxd_q[7:0];
            assign unit_completes = 1'b1;
        end else begin : g_mii
            assign asm_byte       = {rxd_q[3:0], nib_lo_q};
            assign unit_completes = half_q;
        end
    endgenerate

    assign sfd_hit   = (state_q == PREAMBLE) && rxdv_q && (rxd_q == SFD_C) && (pre_cnt_q >= MIN_PRE_C);
    assign data_byte = (state_q == DATA) && rxdv_q && unit_completes;

`ifdef MII_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d, crc_step;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (asm_byte),
        .crc_out (crc_step)
    );

    assign fcs_err = (bitrev32(crc_q) != CRC_RESIDUE);

    // CRC restarts at SFD and advances on every assembled byte, forwarded or not
    always_comb begin
        crc_d = crc_q;
        if (sfd_hit) begin
            crc_d = CRC_INIT;
        end else if (data_byte) begin
            crc_d = crc_step;
        end
    end

    // CRC state register
    always_ff @(posedge rxc or posedge rst) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end
`else
    assign fcs_err = 1'b0;
`endif

    // Input capture; a frame in flight at reset release is ignored until rxdv is seen low
    always_ff @(posedge rxc or posedge rst) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            rxd_q     <= '0;
            rxdv_q    <= 1'b0;
            sampled_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            rxd_q     <= rxd;
            rxdv_q    <= rxdv;
            sampled_q <= 1'b1;
            armed_q   <= armed_q | (sampled_q & ~rxdv_q);
        end
    end

    // Next-state and next-output logic of the framing FSM
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        byte_cnt_d = byte_cnt_q;
        half_d     = half_q;
        nib_lo_d   = nib_lo_q;
        over_d     = over_q;
        data_d     = out_data;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        done_d     = 1'b0;
        len_d      = out_len;
        err_d      = out_err;
        drop_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (armed_q && rxdv_q) begin
                    if (rxd_q == PRE_C) begin
                        state_d   = PREAMBLE;
                        pre_cnt_d = PRE_CW'(1);
                    end else begin
                        state_d = DROP;
                        drop_d  = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!rxdv_q) begin
                    state_d = IDLE;
                end else if (rxd_q == PRE_C) begin
                    if (pre_cnt_q != '1) begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end else if (sfd_hit) begin
                    state_d    = DATA;
                    byte_cnt_d = '0;
                    half_d     = 1'b0;
                    over_d     = 1'b0;
                end else begin
                    state_d = DROP;
                    drop_d  = 1'b1;
                end
            end
            DATA: begin
                if (!rxdv_q) begin
                    // End of frame; a pending half byte is discarded and flagged
                    state_d              = IDLE;
                    done_d               = 1'b1;
                    len_d                = byte_cnt_q;
                    err_d                = '0;
                    err_d[ERR_RUNT]      = (byte_cnt_q < MIN_LEN_C);
                    err_d[ERR_OVERSIZE]  = over_q;
                    err_d[ERR_ODD]       = half_q;
                    err_d[ERR_FCS]       = fcs_err;
                end else if (!unit_completes) begin
                    half_d   = 1'b1;
                    nib_lo_d = rxd_q[3:0];
                end else begin
                    half_d = 1'b0;
                    if (byte_cnt_q < MAX_LEN_C) begin
                        valid_d = 1'b1;
                        data_d  = asm_byte;
                        sof_d   = (byte_cnt_q == '0);
                    end else begin
                        over_d = 1'b1;
                    end
                    if (byte_cnt_q != '1) begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            DROP: begin
                if (!rxdv_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge rxc or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            byte_cnt_q <= '0;
            half_q     <= 1'b0;
            nib_lo_q   <= '0;
            over_q     <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_done   <= 1'b0;
            out_len    <= '0;
            out_err    <= '0;
            out_drop   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            half_q     <= half_d;
            nib_lo_q   <= nib_lo_d;
            over_q     <= over_d;
            out_data   <= data_d;
            out_valid  <= valid_d;
            out_sof    <= sof_d;
            out_done   <= done_d;
            out_len    <= len_d;
            out_err    <= err_d;
            out_drop   <= drop_d;
        end
    end

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer: an MII (4-bit) instance and a GMII (8-bit)
// instance share clock and reset. Frames carry a correct FCS unless a test
// corrupts one; expected bytes, lengths and error codes are built here.
module tb_mii_rx_framer;

`ifdef MII_RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    logic        rxc = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rxd4 = '0;
    logic        rxdv4 = 1'b0;
    logic [7:0]  rxd8 = '0;
    logic        rxdv8 = 1'b0;

    logic [7:0]  o4_data, o8_data;
    logic        o4_valid, o4_sof, o4_done, o4_drop;
    logic        o8_valid, o8_sof, o8_done, o8_drop;
    logic [15:0] o4_len, o8_len;
    logic [3:0]  o4_err, o8_err;

    always #5 rxc = ~rxc;

    mii_rx_framer #(.DATA_W(4), .MIN_PRE(7), .MIN_LEN(64), .MAX_LEN(1518), .LEN_W(16)) u4 (
        .rxc(rxc), .rst(rst), .rxd(rxd4), .rxdv(rxdv4),
        .out_data(o4_data), .out_valid(o4_valid), .out_sof(o4_sof), .out_done(o4_done),
        .out_len(o4_len), .out_err(o4_err), .out_drop(o4_drop)
    );

    mii_rx_framer #(.DATA_W(8), .MIN_PRE(7), .MIN_LEN(64), .MAX_LEN(1518), .LEN_W(16)) u8 (
        .rxc(rxc), .rst(rst), .rxd(rxd8), .rxdv(rxdv8),
        .out_data(o8_data), .out_valid(o8_valid), .out_sof(o8_sof), .out_done(o8_done),
        .out_len(o8_len), .out_err(o8_err), .out_drop(o8_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_b [0:2047];

    // Output monitors (sample on the falling edge)
    int v4 = 0, sof4 = 0, sofbad4 = 0, done4 = 0, drop4 = 0, fb4 = 0;
    logic [7:0]  rx4   [0:8191];
    logic [15:0] lenh4 [0:15];
    logic [3:0]  errh4 [0:15];

    always @(negedge rxc) begin
        if (rst) begin
            fb4 <= 0;
        end else begin
            if (o4_valid) begin
                rx4[v4 % 8192] <= o4_data;
                v4  <= v4 + 1;
                fb4 <= fb4 + 1;
                if (o4_sof != (fb4 == 0)) sofbad4 <= sofbad4 + 1;
            end else if (o4_sof) begin
                sofbad4 <= sofbad4 + 1;
            end
            if (o4_sof)  sof4  <= sof4 + 1;
            if (o4_drop) drop4 <= drop4 + 1;
            if (o4_done) begin
                lenh4[done4 % 16] <= o4_len;
                errh4[done4 % 16] <= o4_err;
                done4 <= done4 + 1;
                fb4   <= 0;
            end
        end
    end

    int v8 = 0, sof8 = 0, done8 = 0;
    logic [7:0]  rx8 [0:255];
    logic [15:0] len8;
    logic [3:0]  err8;

    always @(negedge rxc) begin
        if (!rst) begin
            if (o8_valid) begin
                rx8[v8 % 256] <= o8_data;
                v8 <= v8 + 1;
            end
            if (o8_sof) sof8 <= sof8 + 1;
            if (o8_done) begin
                len8  <= o8_len;
                err8  <= o8_err;
                done8 <= done8 + 1;
            end
        end
    end

    // Reference CRC-32 step (Ethernet, LSB first)
    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Random payload of nbytes-4 bytes followed by its FCS, low byte first
    task automatic build_frame(input int nbytes);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < nbytes - 4; i++) begin
            exp_b[i] = 8'($urandom);
            c = ref_crc(c, exp_b[i]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_b[nbytes - 4 + k] = c[8*k +: 8];
    endtask

    function automatic int bad4(input int base, input int n);
        int b = 0;
        for (int i = 0; i < n; i++) if (rx4[(base + i) % 8192] !== exp_b[i]) b++;
        return b;
    endfunction

    function automatic int bad8(input int base, input int n);
        int b = 0;
        for (int i = 0; i < n; i++) if (rx8[(base + i) % 256] !== exp_b[i]) b++;
        return b;
    endfunction

    task automatic unit4(input logic [3:0] d);
        @(negedge rxc);
        rxd4 = d;
        rxdv4 = 1'b1;
    endtask

    task automatic idle4(input int n);
        repeat (n) begin
            @(negedge rxc);
            rxd4 = '0;
            rxdv4 = 1'b0;
        end
        #1;
    endtask

    task automatic send4(input int npre, input logic [3:0] sfd, input int nbytes, input bit extra, input int idle);
        for (int i = 0; i < npre; i++) unit4(4'h5);
        unit4(sfd);
        for (int i = 0; i < nbytes; i++) begin
            unit4(exp_b[i][3:0]);
            unit4(exp_b[i][7:4]);
        end
        if (extra) unit4(4'hA);
        idle4(idle);
    endtask

    task automatic send8(input int nbytes, input int idle);
        for (int i = 0; i < 7; i++) begin
            @(negedge rxc); rxd8 = 8'h55; rxdv8 = 1'b1;
        end
        @(negedge rxc); rxd8 = 8'hD5;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge rxc); rxd8 = exp_b[i];
        end
        repeat (idle) begin
            @(negedge rxc); rxd8 = '0; rxdv8 = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge rxc);
        #1;
        n_checks++; if (o4_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid4: got %b expected 0", o4_valid); end
        n_checks++; if ({o4_data, o4_sof, o4_done, o4_len, o4_err, o4_drop} !== 31'd0) begin
            n_fail++; $display("FAIL reset_outs4: got %h expected 0", {o4_data, o4_sof, o4_done, o4_len, o4_err, o4_drop}); end
        n_checks++; if ({o8_data, o8_valid, o8_sof, o8_done, o8_len, o8_err, o8_drop} !== 32'd0) begin
            n_fail++; $display("FAIL reset_outs8: got %h expected 0", {o8_data, o8_valid, o8_sof, o8_done, o8_len, o8_err, o8_drop}); end
        @(negedge rxc);
        rst = 1'b0;
        idle4(5);
    endtask

    task automatic test_frames();
        int bv, bs, bd, bsb, nb;
        for (int f = 0; f < 10; f++) begin
            build_frame(650);
            bv = v4; bs = sof4; bd = done4; bsb = sofbad4;
            send4(15, 4'hD, 650, 1'b0, 500);
            n_checks++; if (v4 - bv !== 650) begin n_fail++; $display("FAIL frame%0d_valid: got %0d expected 650", f, v4 - bv); end
            n_checks++; if (sof4 - bs !== 1) begin n_fail++; $display("FAIL frame%0d_sof: got %0d expected 1", f, sof4 - bs); end
            n_checks++; if (sofbad4 !== bsb) begin n_fail++; $display("FAIL frame%0d_sof_pos: got %0d misplaced expected 0", f, sofbad4 - bsb); end
            n_checks++; if (done4 - bd !== 1) begin n_fail++; $display("FAIL frame%0d_done: got %0d expected 1", f, done4 - bd); end
            n_checks++; if (lenh4[(done4 - 1) % 16] !== 16'd650) begin n_fail++; $display("FAIL frame%0d_len: got %0d expected 650", f, lenh4[(done4 - 1) % 16]); end
            n_checks++; if (errh4[(done4 - 1) % 16] !== 4'b0000) begin n_fail++; $display("FAIL frame%0d_err: got %b expected 0000", f, errh4[(done4 - 1) % 16]); end
            nb = bad4(bv, 650);
            n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL frame%0d_data: got %0d wrong bytes expected 0", f, nb); end
        end
    endtask

    task automatic test_short_preamble();
        int bv, bd, bdr;
        build_frame(20);
        bv = v4; bd = done4; bdr = drop4;
        send4(6, 4'hD, 10, 1'b0, 20);
        n_checks++; if (drop4 - bdr !== 1) begin n_fail++; $display("FAIL short_pre_drop: got %0d expected 1", drop4 - bdr); end
        n_checks++; if (v4 - bv !== 0) begin n_fail++; $display("FAIL short_pre_valid: got %0d expected 0", v4 - bv); end
        n_checks++; if (done4 - bd !== 0) begin n_fail++; $display("FAIL short_pre_done: got %0d expected 0", done4 - bd); end
    endtask

    task automatic test_odd_nibble();
        int bv, nb;
        build_frame(650);
        bv = v4;
        send4(15, 4'hD, 650, 1'b1, 20);
        n_checks++; if (v4 - bv !== 650) begin n_fail++; $display("FAIL odd_valid: got %0d expected 650", v4 - bv); end
        n_checks++; if (lenh4[(done4 - 1) % 16] !== 16'd650) begin n_fail++; $display("FAIL odd_len: got %0d expected 650", lenh4[(done4 - 1) % 16]); end
        n_checks++; if (errh4[(done4 - 1) % 16] !== 4'b0100) begin n_fail++; $display("FAIL odd_err: got %b expected 0100", errh4[(done4 - 1) % 16]); end
        nb = bad4(bv, 650);
        n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL odd_data: got %0d wrong bytes expected 0", nb); end
    endtask

    task automatic test_length_limits();
        int bv, bd, nb;
        build_frame(1550);
        bv = v4;
        send4(15, 4'hD, 1550, 1'b0, 20);
        n_checks++; if (v4 - bv !== 1518) begin n_fail++; $display("FAIL over_valid: got %0d expected 1518", v4 - bv); end
        n_checks++; if (lenh4[(done4 - 1) % 16] !== 16'd1550) begin n_fail++; $display("FAIL over_len: got %0d expected 1550", lenh4[(done4 - 1) % 16]); end
        n_checks++; if (errh4[(done4 - 1) % 16] !== 4'b0010) begin n_fail++; $display("FAIL over_err: got %b expected 0010", errh4[(done4 - 1) % 16]); end
        nb = bad4(bv, 1518);
        n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL over_data: got %0d wrong bytes expected 0", nb); end

        build_frame(20);
        bv = v4;
        send4(15, 4'hD, 20, 1'b0, 20);
        n_checks++; if (v4 - bv !== 20) begin n_fail++; $display("FAIL runt_valid: got %0d expected 20", v4 - bv); end
        n_checks++; if (lenh4[(done4 - 1) % 16] !== 16'd20) begin n_fail++; $display("FAIL runt_len: got %0d expected 20", lenh4[(done4 - 1) % 16]); end
        n_checks++; if (errh4[(done4 - 1) % 16] !== 4'b0001) begin n_fail++; $display("FAIL runt_err: got %b expected 0001", errh4[(done4 - 1) % 16]); end

        bv = v4; bd = done4;
        send4(15, 4'hD, 0, 1'b0, 20);
        n_checks++; if (done4 - bd !== 1) begin n_fail++; $display("FAIL empty_done: got %0d expected 1", done4 - bd); end
        n_checks++; if (v4 - bv !== 0) begin n_fail++; $display("FAIL empty_valid: got %0d expected 0", v4 - bv); end
        n_checks++; if (lenh4[(done4 - 1) % 16] !== 16'd0) begin n_fail++; $display("FAIL empty_len: got %0d expected 0", lenh4[(done4 - 1) % 16]); end
        n_checks++; if (errh4[(done4 - 1) % 16] !== {FCS_EN, 3'b001}) begin
            n_fail++; $display("FAIL empty_err: got %b expected %b", errh4[(done4 - 1) % 16], {FCS_EN, 3'b001}); end
    endtask

    task automatic test_back_to_back();
        int bv, bs, bd, nb;
        bv = v4; bs = sof4; bd = done4;
        build_frame(70);
        send4(15, 4'hD, 70, 1'b0, 1);
        build_frame(80);
        send4(15, 4'hD, 80, 1'b0, 20);
        n_checks++; if (done4 - bd !== 2) begin n_fail++; $display("FAIL b2b_done: got %0d expected 2", done4 - bd); end
        n_checks++; if (sof4 - bs !== 2) begin n_fail++; $display("FAIL b2b_sof: got %0d expected 2", sof4 - bs); end
        n_checks++; if (v4 - bv !== 150) begin n_fail++; $display("FAIL b2b_valid: got %0d expected 150", v4 - bv); end
        n_checks++; if ({lenh4[(done4 - 2) % 16], lenh4[(done4 - 1) % 16]} !== {16'd70, 16'd80}) begin
            n_fail++; $display("FAIL b2b_len: got %0d,%0d expected 70,80", lenh4[(done4 - 2) % 16], lenh4[(done4 - 1) % 16]); end
        n_checks++; if ({errh4[(done4 - 2) % 16], errh4[(done4 - 1) % 16]} !== 8'h00) begin
            n_fail++; $display("FAIL b2b_err: got %b,%b expected 0000,0000", errh4[(done4 - 2) % 16], errh4[(done4 - 1) % 16]); end
        nb = bad4(bv + 70, 80);
        n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL b2b_data: got %0d wrong bytes expected 0", nb); end
    endtask

    task automatic test_gmii_fcs();
        int bv, bs, bd, nb;
        build_frame(64);
        bv = v8; bs = sof8; bd = done8;
        send8(64, 20);
        n_checks++; if (v8 - bv !== 64) begin n_fail++; $display("FAIL gmii_valid: got %0d expected 64", v8 - bv); end
        n_checks++; if (sof8 - bs !== 1) begin n_fail++; $display("FAIL gmii_sof: got %0d expected 1", sof8 - bs); end
        n_checks++; if (done8 - bd !== 1) begin n_fail++; $display("FAIL gmii_done: got %0d expected 1", done8 - bd); end
        n_checks++; if (len8 !== 16'd64) begin n_fail++; $display("FAIL gmii_len: got %0d expected 64", len8); end
        n_checks++; if (err8 !== 4'b0000) begin n_fail++; $display("FAIL gmii_err: got %b expected 0000", err8); end
        nb = bad8(bv, 64);
        n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL gmii_data: got %0d wrong bytes expected 0", nb); end

        exp_b[10] = exp_b[10] ^ 8'h04;
        send8(64, 20);
        n_checks++; if (len8 !== 16'd64) begin n_fail++; $display("FAIL gmii_bad_len: got %0d expected 64", len8); end
        n_checks++; if (err8 !== {FCS_EN, 3'b000}) begin n_fail++; $display("FAIL gmii_bad_err: got %b expected %b", err8, {FCS_EN, 3'b000}); end
    endtask

    task automatic test_reset_midframe();
        int bv, bd, bs, nb;
        build_frame(700);
        for (int i = 0; i < 15; i++) unit4(4'h5);
        unit4(4'hD);
        for (int i = 0; i < 300; i++) begin
            unit4(exp_b[i][3:0]);
            unit4(exp_b[i][7:4]);
        end
        @(negedge rxc);
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({o4_valid, o4_sof, o4_done, o4_drop} !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_strobes: got %b expected 0000", {o4_valid, o4_sof, o4_done, o4_drop}); end
        n_checks++; if ({o4_data, o4_len, o4_err} !== 28'd0) begin
            n_fail++; $display("FAIL midrst_outs: got %h expected 0", {o4_data, o4_len, o4_err}); end
        bv = v4; bd = done4;
        for (int i = 300; i < 310; i++) begin
            unit4(exp_b[i][3:0]);
            unit4(exp_b[i][7:4]);
        end
        @(negedge rxc);
        rst = 1'b0;
        for (int i = 310; i < 700; i++) begin
            unit4(exp_b[i][3:0]);
            unit4(exp_b[i][7:4]);
        end
        idle4(20);
        n_checks++; if (v4 - bv !== 0) begin n_fail++; $display("FAIL midrst_valid: got %0d expected 0", v4 - bv); end
        n_checks++; if (done4 - bd !== 0) begin n_fail++; $display("FAIL midrst_done: got %0d expected 0", done4 - bd); end

        build_frame(100);
        bv = v4; bd = done4; bs = sof4;
        send4(15, 4'hD, 100, 1'b0, 20);
        n_checks++; if (v4 - bv !== 100) begin n_fail++; $display("FAIL postrst_valid: got %0d expected 100", v4 - bv); end
        n_checks++; if (sof4 - bs !== 1) begin n_fail++; $display("FAIL postrst_sof: got %0d expected 1", sof4 - bs); end
        n_checks++; if (done4 - bd !== 1) begin n_fail++; $display("FAIL postrst_done: got %0d expected 1", done4 - bd); end
        n_checks++; if (lenh4[(done4 - 1) % 16] !== 16'd100) begin n_fail++; $display("FAIL postrst_len: got %0d expected 100", lenh4[(done4 - 1) % 16]); end
        n_checks++; if (errh4[(done4 - 1) % 16] !== 4'b0000) begin n_fail++; $display("FAIL postrst_err: got %b expected 0000", errh4[(done4 - 1) % 16]); end
        nb = bad4(bv, 100);
        n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL postrst_data: got %0d wrong bytes expected 0", nb); end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_short_preamble();
        test_odd_nibble();
        test_length_limits();
        test_back_to_back();
        test_gmii_fcs();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
